// File: rtl/md_unit_iter_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default latency.
package md_unit_iter_pkg;

    typedef enum logic [3:0] {
        OP_MULTU = 4'd0,
        OP_MULT  = 4'd1,
        OP_DIVU  = 4'd2,
        OP_DIV   = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MADD  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MSUB  = 4'd9
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    localparam int MD_LAT_DEFAULT = 5;

    // Codes 10..15 are NOPs and are never accepted.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd9;
    endfunction

endpackage

// File: rtl/md_unit_iter_div.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle, WIDTH cycles.
module md_unit_iter_div
    import md_unit_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             kill,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             valid
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q, valid_q;
    logic [WIDTH:0]   rem_sh_d, diff_d;
    logic [WIDTH-1:0] quo_d, rem_d;

    always_comb begin
        rem_sh_d = {rem_q, quo_q[WIDTH-1]};
        diff_d   = rem_sh_d - {1'b0, dvs_q};
        if (!diff_d[WIDTH]) begin
            rem_d = diff_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (go) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (run_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (kill) begin
                run_q <= 1'b0;
            end else if (go) begin
                run_q <= 1'b1;
                cnt_q <= CNT_W'(WIDTH);
            end else if (run_q) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign q     = quo_q;
    assign r     = rem_q;
    assign valid = valid_q;

endmodule

// File: rtl/md_unit_iter.sv
// Multiply/divide unit with HI/LO, fixed-latency multiply, iterative divide and one-deep rollback snapshot.
module md_unit_iter
    import md_unit_iter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MD_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int W2      = 2 * WIDTH;

    md_state_e        state_q;
    md_op_e           op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, div0_q, zero_q, negq_q, negr_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
    logic [W2-1:0]    snap_q;

    logic                 accept_d, is_div_d, a_neg_d, b_neg_d, div_go_d, signed_mul_d;
    logic [WIDTH-1:0]     a_mag_d, b_mag_d, quo_d, rem_d;
    logic [WIDTH-1:0]     div_q, div_r;
    logic                 div_valid;
    logic [W2-1:0]        hilo_d, prod_u_d, prod_d, mul_d;
    logic signed [W2-1:0] prod_s_d;

    always_comb begin
        accept_d = (state_q == S_IDLE) && start && !cancel && op_legal(op);
        is_div_d = (op == OP_DIVU) || (op == OP_DIV);
        a_neg_d  = (op == OP_DIV) && a[WIDTH-1];
        b_neg_d  = (op == OP_DIV) && b[WIDTH-1];
        a_mag_d  = a_neg_d ? -a : a;
        b_mag_d  = b_neg_d ? -b : b;
        div_go_d = accept_d && is_div_d && (b != '0);
    end

    // Multiply-accumulate datapath on latched operands; HI/LO wrap mod 2^(2*WIDTH).
    always_comb begin
        hilo_d       = {hi_q, lo_q};
        prod_s_d     = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u_d     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        signed_mul_d = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        prod_d       = signed_mul_d ? $unsigned(prod_s_d) : prod_u_d;
        case (op_q)
            OP_MADDU, OP_MADD: mul_d = hilo_d + prod_d;
            OP_MSUBU, OP_MSUB: mul_d = hilo_d - prod_d;
            default:           mul_d = prod_d;
        endcase
        quo_d = negq_q ? -div_q : div_q;
        rem_d = negr_q ? -div_r : div_r;
    end

    always_ff @(posedge clk) begin
        if (accept_d) begin
            op_q   <= md_op_e'(op);
            a_q    <= a;
            b_q    <= b;
            negq_q <= a_neg_d ^ b_neg_d;
            negr_q <= a_neg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            snap_q  <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            if (cancel) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                {hi_q, lo_q} <= snap_q;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept_d) begin
                            snap_q <= {hi_q, lo_q};
                            case (md_op_e'(op))
                                OP_MTHI: hi_q <= a;
                                OP_MTLO: lo_q <= a;
                                OP_DIVU, OP_DIV: begin
                                    busy_q  <= 1'b1;
                                    zero_q  <= (b == '0);
                                    cnt_q   <= CNT_W'(WIDTH);
                                    state_q <= (b == '0) ? S_FIX : S_DIV;
                                end
                                default: begin
                                    busy_q  <= 1'b1;
                                    cnt_q   <= CNT_W'(MUL_LAT);
                                    state_q <= S_MUL;
                                end
                            endcase
                        end
                    end
                    S_MUL: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            {hi_q, lo_q} <= mul_d;
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (zero_q) begin
                            div0_q <= 1'b1;
                        end else if (div_valid) begin
                            hi_q <= rem_d;
                            lo_q <= quo_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    md_unit_iter_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .go       (div_go_d),
        .kill     (cancel),
        .dividend (a_mag_d),
        .divisor  (b_mag_d),
        .q        (div_q),
        .r        (div_r),
        .valid    (div_valid)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed and randomized bench for md_unit_iter against an arithmetic HI/LO reference model.
module tb_md_unit_iter;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          reset, start, cancel;
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, div0;
    logic [W-1:0]  hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]   m_hi, m_lo;
    logic [2*W-1:0] m_snap;

    md_unit_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: architectural effect of one accepted op, plus expected busy/done/div0 counts.
    task automatic model_apply(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int eb, output int ed, output int ez);
        logic [63:0] hl, pu, ps;
        longint      sa, sb, sq, sr;
        hl = {m_hi, m_lo};
        eb = 0; ed = 0; ez = 0;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        pu = 64'(x) * 64'(y);
        ps = 64'(sa * sb);
        if (o <= 4'd9) begin
            m_snap = hl;
            case (o)
                4'd0: hl = pu;
                4'd1: hl = ps;
                4'd6: hl = hl + pu;
                4'd7: hl = hl + ps;
                4'd8: hl = hl - pu;
                4'd9: hl = hl - ps;
                4'd4: hl[63:32] = x;
                4'd5: hl[31:0] = x;
                default: begin
                    if (y == 0) begin
                        eb = 1; ed = 1; ez = 1;
                    end else begin
                        eb = W + 1; ed = 1;
                        if (o == 4'd2) begin
                            hl = {x % y, x / y};
                        end else begin
                            sq = sa / sb;
                            sr = sa % sb;
                            hl = {sr[31:0], sq[31:0]};
                        end
                    end
                end
            endcase
            if (o inside {4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9}) begin
                eb = LAT; ed = 1;
            end
        end
        {m_hi, m_lo} = hl;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int eb, ed, ez, bc, dc, zc;
        model_apply(o, x, y, eb, ed, ez);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        bc = 0; dc = 0; zc = 0;
        for (int i = 0; i < 200; i++) begin
            dc += int'(done);
            zc += int'(div0);
            if (!busy) break;
            bc++;
            if (i == 1 && eb >= 3) begin
                start = 1'b1;
                op = 4'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        dc += int'(done);
        zc += int'(div0);
        chk({tag, "_busy"}, 64'(bc), 64'(eb));
        chk({tag, "_done"}, 64'(dc), 64'(ed));
        chk({tag, "_div0"}, 64'(zc), 64'(ez));
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int eb, ed, ez, cnt;
        logic [63:0] pre;
        logic [3:0]  ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0; m_snap = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFA);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_op("divu", 4'd2, 32'hFFFF_FFF9, 32'd2);
        chk("divu_lo_k", 64'(lo), 64'h0000_0000_7FFF_FFFC);
        chk("divu_hi_k", 64'(hi), 64'd1);

        run_op("mthi11", 4'd4, 32'h11, 32'h0);
        run_op("mtlo22", 4'd5, 32'h22, 32'h0);
        run_op("divz", 4'd2, 32'h1234_5678, 32'h0);
        chk("divz_hi_k", 64'(hi), 64'h11);
        chk("divz_lo_k", 64'(lo), 64'h22);

        // Cancel an in-flight DIVU in its third busy cycle.
        pre = {m_hi, m_lo};
        model_apply(4'd2, 32'h0000_9999, 32'd7, eb, ed, ez);
        @(negedge clk); start = 1'b1; op = 4'd2; a = 32'h0000_9999; b = 32'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        {m_hi, m_lo} = m_snap;
        chk("cdiv_busy", 64'(busy), 64'd0);
        chk("cdiv_hilo", {hi, lo}, pre);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cnt += int'(done);
            @(negedge clk);
        end
        chk("cdiv_nodone", 64'(cnt), 64'd0);

        // MTHI then cancel: hi returns to its previous value.
        run_op("mthi5", 4'd4, 32'h5, 32'h0);
        model_apply(4'd4, 32'h1234, 32'h0, eb, ed, ez);
        @(negedge clk); start = 1'b1; op = 4'd4; a = 32'h1234;
        @(negedge clk); start = 1'b0;
        chk("mthi_wr", 64'(hi), 64'h1234);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        {m_hi, m_lo} = m_snap;
        chk("mthi_cancel", 64'(hi), 64'(m_hi));
        chk("mthi_cancel_k", 64'(hi), 64'h5);

        // Start and cancel in the same cycle: nothing is accepted.
        @(negedge clk); start = 1'b1; cancel = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
        @(negedge clk); start = 1'b0; cancel = 1'b0;
        {m_hi, m_lo} = m_snap;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(busy) + int'(done);
            @(negedge clk);
        end
        chk("sc_idle", 64'(cnt), 64'd0);
        chk("sc_hilo", {hi, lo}, {m_hi, m_lo});

        run_op("madd_h", 4'd4, 32'h0, 32'h0);
        run_op("madd_l", 4'd5, 32'hFFFF_FFFF, 32'h0);
        run_op("madd", 4'd7, 32'd2, 32'd3);
        chk("madd_k", {hi, lo}, 64'h0000_0001_0000_0005);

        run_op("msub_h", 4'd4, 32'h0, 32'h0);
        run_op("msub_l", 4'd5, 32'h0, 32'h0);
        run_op("msubu", 4'd8, 32'd1, 32'd1);
        chk("msubu_k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf_k", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op("nop", 4'd12, 32'hDEAD_BEEF, 32'h3);

        // Reset in the middle of a divide.
        @(negedge clk); start = 1'b1; op = 4'd3; a = $urandom; b = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_hi = '0; m_lo = '0; m_snap = '0;
        chk("rstdiv_busy", 64'(busy), 64'd0);
        chk("rstdiv_hilo", {hi, lo}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cnt += int'(done);
            @(negedge clk);
        end
        chk("rstdiv_nodone", 64'(cnt), 64'd0);

        for (int n = 0; n < 60; n++) begin
            ro = 4'($urandom_range(0, 11));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = '1; end
                default: ;
            endcase
            run_op("rnd", ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
